banco_de_registradores: RTL and testbench
=========================================

// Module: banco_de_registradores
// PURPOSE
// - Processor register bank: 32 general registers plus special registers HI, LO, CM (compare flag),
//   AS (call-stack address), SP (data-stack pointer) and TIME (cycle counter).
// - Two combinational read ports feed the ULA; one GPR write port takes the ULA/memory result.
// - A HI/LO pair captures both ULA outputs. Stack pointers are stepped by ctrl stack bits.
// - JR is a special-read mux for jump targets and shift operands.
// PARAMETERS
// - WIDTH     32  data width of every register
// - SP_STEP   4   byte step applied to SP on data-stack push/pop
// - SP_RESET  0   SP value after reset
// PORTS
// - clk    in   1      rising-edge clock
// - rst_n  in   1      asynchronous, active-low reset
// - RL0    in   5      read address, port 0
// - RL1    in   5      read address, port 1
// - RE0    in   5      write address; also the JR/RF source address
// - esc0   in   WIDTH  GPR write data; LO write data
// - esc1   in   WIDTH  HI write data
// - comp   in   1      ULA compare result
// - ctrl   in   8      [0]EscReg1 [1]EscReg2 [2]Pilha1 [3]Pilha2 [4]EmpDesemp [7:5]JR select
// - D0     out  WIDTH  reg[RL0]
// - D1     out  WIDTH  reg[RL1]
// - CM     out  1      registered compare flag
// - AS     out  WIDTH  call-stack address
// - SP     out  WIDTH  data-stack pointer
// - JR     out  WIDTH  special-read mux output
// - RF     out  WIDTH  reg[RE0], debug view
// BEHAVIOUR
// - Reset (rst_n=0, async, takes effect immediately, including mid-operation):
//   - all GPRs, HI, LO, AS and TIME = 0; CM = 0; SP = SP_RESET.
// - Reads are combinational: D0, D1, RF, JR. A read during a write returns the old value;
//   the new value is visible after the edge.
// - reg[0] reads as 0 always; writes to it are discarded.
// - On each rising clk edge (rst_n=1); all updates use pre-edge values:
//   - EscReg1: reg[RE0] <= esc0.
//   - EscReg2: LO <= esc0, HI <= esc1. May coincide with EscReg1; both take effect.
//   - CM <= comp only when ctrl[3:0]==0 and ctrl[7:5]==0; otherwise CM holds.
//   - Pilha1 & EmpDesemp (call): AS <= AS+1.
//   - Pilha1 & !EmpDesemp (return): AS <= AS-1.
//   - Pilha2 & EmpDesemp (push): SP <= SP+SP_STEP.
//   - Pilha2 & !EmpDesemp (pop): SP <= SP-SP_STEP.
//   - Pilha1 and Pilha2 set together: both pointers update.
//   - TIME <= TIME+1 every cycle.
// - AS and SP arithmetic is modulo 2^WIDTH: pop/return at 0 wraps to all-ones or 2^WIDTH-SP_STEP.
//   No error flag is raised.
// - JR by ctrl[7:5]:
//   - 000, 001 -> reg[RE0]
//   - 010 -> HI
//   - 011 -> LO
//   - 100 -> TIME
//   - 101..111 -> 0
// - Single clock domain; no handshakes; write latency 1 cycle, read latency 0.
// TESTING
// - Reset: pulse rst_n low mid-cycle -> all outputs 0 immediately (SP=SP_RESET), held while low.
// - Write/read: EscReg1, RE0=5, esc0=0xDEADBEEF; next cycle RL0=5, RL1=5 -> D0=D1=0xDEADBEEF;
//   RE0=0 write of 0x1234 -> D0 with RL0=0 reads 0.
// - HI/LO: EscReg2, esc0=0x11, esc1=0x22, then ctrl[7:5]=010 -> JR=0x22; 011 -> JR=0x11.
// - Stacks from reset:
//   - two calls -> AS=2; one return -> AS=1.
//   - push -> SP=4; two pops -> SP=0xFFFFFFFC.
// - CM: comp=1 with ctrl=0 -> CM=1 next cycle; comp=0 with EscReg1=1 -> CM stays 1.
// - TIME: 10 cycles after reset release, ctrl[7:5]=100 -> JR=10.

Source files
------------

// File: rtl/banco_de_registradores.sv
// Register bank: 32 GPRs with two combinational read ports and one write port,
// plus HI/LO, compare flag, call/data stack pointers and a free-running cycle counter.
module banco_de_registradores #(
   parameter int WIDTH    = 32,
   parameter int SP_STEP  = 4,
   parameter int SP_RESET = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RL0,
   input  logic [4:0]       RL1,
   input  logic [4:0]       RE0,
   input  logic [WIDTH-1:0] esc0,
   input  logic [WIDTH-1:0] esc1,
   input  logic             comp,
   input  logic [7:0]       ctrl,
   output logic [WIDTH-1:0] D0,
   output logic [WIDTH-1:0] D1,
   output logic             CM,
   output logic [WIDTH-1:0] AS,
   output logic [WIDTH-1:0] SP,
   output logic [WIDTH-1:0] JR,
   output logic [WIDTH-1:0] RF
);

   logic             esc_reg1, esc_reg2, pilha1, pilha2, emp;
   logic [2:0]       jr_sel;
   logic             cm_upd;
   logic [WIDTH-1:0] regs [32];
   logic [WIDTH-1:0] hi, lo, time_cnt;

   assign esc_reg1 = ctrl[0];
   assign esc_reg2 = ctrl[1];
   assign pilha1   = ctrl[2];
   assign pilha2   = ctrl[3];
   assign emp      = ctrl[4];
   assign jr_sel   = ctrl[7:5];
   // Compare flag only latches on an otherwise idle control word.
   assign cm_upd   = (ctrl[3:0] == 4'd0) && (jr_sel == 3'd0);

   assign regs[0] = '0;

   for (genvar i = 1; i < 32; i++) begin : g_gpr
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            regs[i] <= '0;
         else if (esc_reg1 && (RE0 == 5'(i)))
            regs[i] <= esc0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         CM       <= 1'b0;
         AS       <= '0;
         SP       <= WIDTH'(SP_RESET);
         time_cnt <= '0;
      end else begin
         time_cnt <= time_cnt + 1'b1;
         if (esc_reg2) begin
            lo <= esc0;
            hi <= esc1;
         end
         if (cm_upd)
            CM <= comp;
         if (pilha1)
            AS <= emp ? AS + 1'b1 : AS - 1'b1;
         if (pilha2)
            SP <= emp ? SP + WIDTH'(SP_STEP) : SP - WIDTH'(SP_STEP);
      end
   end

   assign D0 = regs[RL0];
   assign D1 = regs[RL1];
   assign RF = regs[RE0];

   always_comb begin
      JR = '0;
      case (jr_sel)
         3'd0, 3'd1: JR = regs[RE0];
         3'd2:       JR = hi;
         3'd3:       JR = lo;
         3'd4:       JR = time_cnt;
         default:    JR = '0;
      endcase
   end

endmodule

// File: tb/tb_banco_de_registradores.sv
// Directed test of the register bank: reset, GPR access, HI/LO, stacks, compare flag, cycle counter.
module tb_banco_de_registradores;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  RL0, RL1, RE0;
   logic [31:0] esc0, esc1;
   logic        comp;
   logic [7:0]  ctrl;
   logic [31:0] D0, D1, AS, SP, JR, RF;
   logic        CM;

   int checks = 0;
   int errors = 0;

   banco_de_registradores dut (
      .clk(clk), .rst_n(rst_n), .RL0(RL0), .RL1(RL1), .RE0(RE0),
      .esc0(esc0), .esc1(esc1), .comp(comp), .ctrl(ctrl),
      .D0(D0), .D1(D1), .CM(CM), .AS(AS), .SP(SP), .JR(JR), .RF(RF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; RL0 = 0; RL1 = 0; RE0 = 0;
      esc0 = 0; esc1 = 0; comp = 0; ctrl = 8'h00;
      #22 rst_n = 1'b1;

      // TIME: ten edges after release
      repeat (10) step();
      ctrl = 8'h80; #1;
      chk("time10", JR, 32'd10);

      // GPR write then read on both ports
      ctrl = 8'h01; RE0 = 5; esc0 = 32'hDEADBEEF;
      step();
      ctrl = 8'h00; RL0 = 5; RL1 = 5; #1;
      chk("d0_r5", D0, 32'hDEADBEEF);
      chk("d1_r5", D1, 32'hDEADBEEF);
      chk("rf_r5", RF, 32'hDEADBEEF);
      chk("jr_r5", JR, 32'hDEADBEEF);

      // read during write sees the old value
      ctrl = 8'h01; esc0 = 32'h0000CAFE; #1;
      chk("rdw_old", D0, 32'hDEADBEEF);
      step();
      ctrl = 8'h00;
      chk("rdw_new", D0, 32'h0000CAFE);

      // writes to reg 0 are discarded
      ctrl = 8'h01; RE0 = 0; esc0 = 32'h1234;
      step();
      ctrl = 8'h00; RL0 = 0; #1;
      chk("r0_d0", D0, 32'h0);
      chk("r0_rf", RF, 32'h0);

      // HI/LO together with a GPR write
      ctrl = 8'h03; RE0 = 7; esc0 = 32'h11; esc1 = 32'h22;
      step();
      ctrl = 8'h40; #1;
      chk("jr_hi", JR, 32'h22);
      ctrl = 8'h60; #1;
      chk("jr_lo", JR, 32'h11);
      ctrl = 8'hA0; #1;
      chk("jr_zero", JR, 32'h0);
      ctrl = 8'h00; RL1 = 7; #1;
      chk("r7_dual", D1, 32'h11);

      // asynchronous reset mid-cycle
      RL0 = 5; RE0 = 5; comp = 1;
      step();                       // CM <= 1
      chk("cm_pre_rst", {31'd0, CM}, 32'd1);
      ctrl = 8'h60;
      #3 rst_n = 1'b0; #1;
      chk("rst_d0", D0, 32'h0);
      chk("rst_d1", D1, 32'h0);
      chk("rst_rf", RF, 32'h0);
      chk("rst_jr", JR, 32'h0);
      chk("rst_cm", {31'd0, CM}, 32'd0);
      chk("rst_as", AS, 32'h0);
      chk("rst_sp", SP, 32'h0);
      ctrl = 8'h1C;
      step();
      chk("rst_hold_as", AS, 32'h0);
      chk("rst_hold_sp", SP, 32'h0);
      comp = 0;

      // stacks from reset
      rst_n = 1'b1; ctrl = 8'h14;
      step(); step();
      chk("as_call2", AS, 32'd2);
      ctrl = 8'h04; step();
      chk("as_ret1", AS, 32'd1);
      ctrl = 8'h18; step();
      chk("sp_push", SP, 32'd4);
      ctrl = 8'h08; step(); step();
      chk("sp_pop_wrap", SP, 32'hFFFFFFFC);
      ctrl = 8'h04; step(); step();
      chk("as_ret_wrap", AS, 32'hFFFFFFFF);
      ctrl = 8'h1C; step();
      chk("both_as", AS, 32'h0);
      chk("both_sp", SP, 32'h0);

      // compare flag gating
      ctrl = 8'h00; comp = 1; step();
      chk("cm_set", {31'd0, CM}, 32'd1);
      ctrl = 8'h01; RE0 = 0; comp = 0; step();
      chk("cm_hold_esc", {31'd0, CM}, 32'd1);
      ctrl = 8'h80; step();
      chk("cm_hold_jr", {31'd0, CM}, 32'd1);
      ctrl = 8'h00; step();
      chk("cm_clr", {31'd0, CM}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
